ahb_debug_mem_slave: RTL and testbench
======================================

Name: ahb_debug_mem_slave

Overview:
AHB-Lite responder (slave): a word-organised scratch memory. The UART debugger's AHB master issues its reads and writes to this block, so it is the target end of the debugger's bus traffic. It decodes the address phase, inserts programmable wait states and performs byte, halfword and word accesses with lane masking. It returns the two-cycle ERROR response for illegal accesses.

Parameters:
DEPTH, 64, number of 32-bit words; must be a power of two.
WAIT_STATES, 0, extra HREADYOUT-low cycles per accepted transfer (0..7).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
HSEL  input  1  slave select from the address decoder
HADDR  input  32  byte address; bits [log2(DEPTH)+1:0] are used
HWRITE  input  1  1 = write
HSIZE  input  3  0 = byte, 1 = half, 2 = word; others are illegal
HBURST  input  3  ignored; every beat is treated as a single transfer
HTRANS  input  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3
HWDATA  input  32  write data, valid in the data phase
HREADY  input  1  bus-level ready (previous data phase completing)
HREADYOUT  output  1  this slave's ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  32  read data, valid when HREADYOUT = 1 in a read data phase

Behaviour:
- Accept: a transfer is accepted when HSEL & HREADY & HTRANS[1]. On accept, register addr, size, write, error flags and wait count. IDLE/BUSY or HSEL = 0 give a zero-wait OKAY with no access.
- FSM states:
  - IDLE → WAIT on an accepted legal transfer with WAIT_STATES > 0.
  - IDLE → DATA on an accepted legal transfer with WAIT_STATES = 0.
  - IDLE → ERR1 on an accepted illegal transfer.
  - WAIT: counter decrements each cycle; → DATA when it reaches 1.
  - DATA: HREADYOUT = 1 and the access completes. It may accept the next transfer in the same cycle (pipelined) and branch as in IDLE; otherwise → IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1 → ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1; a new accept is allowed; otherwise → IDLE.
- Latency:
  - Data phase lasts 1 + WAIT_STATES cycles.
  - Back-to-back NONSEQs give one transfer per (1 + WAIT_STATES) cycles.
- Writes commit at the clock edge ending the data phase (HREADYOUT = 1). Byte lanes come from addr[1:0] and size:
  - byte: lane = addr[1:0]
  - half: lanes {addr[1], addr[1]} pair
  - word: all four lanes
- Reads: HRDATA = mem[addr word index], combinational from the array during the data phase, full word with all lanes driven. HRDATA = 0 outside a read data phase.
- Read-after-write to the same word in consecutive transfers returns the new data; no hazard, because the write commits before the read's data phase.
- Illegal transfers:
  - HSIZE > 2.
  - addr word index ≥ DEPTH (checked on HADDR above the index bits being nonzero within [15:0]; HADDR[31:16] ignored).
  - Misalignment, only as described under Optional Feature.
  - An illegal transfer produces no memory change.
- Reset: HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM = IDLE, counter = 0, memory cleared to 0. Reset mid-transfer abandons the transfer with no write.
- Simultaneous events: an accept in the final DATA/ERR2 cycle is legal and takes effect at that edge.

Optional Feature:
- Macro AHB_MISALIGN_ERR_EN.
- Defined: half with addr[0] = 1, or word with addr[1:0] ≠ 0, gives the two-cycle ERROR and no write.
- Undefined: low address bits are forced to alignment (half clears bit 0, word clears [1:0]) and the access completes OKAY.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE constants (BYTE, HALF, WORD)
  - HRESP constants (OKAY, ERROR)
  - the FSM state enum
- One sub-module, ahb_byte_strobe: takes addr[1:0] and size, produces a 4-bit lane mask and an aligned flag.

Test Plan:
- Reset: assert rst for 2 cycles → HREADYOUT = 1, HRESP = 0, HRDATA = 0; a read of word 5 returns 0x00000000.
- WAIT_STATES = 0: write word 0x10 = 0xDEADBEEF, then an immediate NONSEQ read of 0x10 → HRDATA = 0xDEADBEEF in the next cycle, HREADYOUT never low.
- Byte write 0xAA to 0x13 over word 0x11223344 → readback 0xAA223344. Half write 0x5566 to 0x10 → readback 0xAA225566.
- WAIT_STATES = 3 → HREADYOUT low exactly 3 cycles per transfer. Two back-to-back reads complete in 8 cycles.
- HADDR = 0x100 with DEPTH = 64 → HRESP = 1 with HREADYOUT = 0, then HRESP = 1 with HREADYOUT = 1; memory unchanged. HSIZE = 3 gives the same result.
- With AHB_MISALIGN_ERR_EN, a word write to 0x02 → ERROR. Without it, the same write lands at word 0x00 with OKAY.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the debug memory slave's FSM state type.
package ahb_pkg;

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;

    localparam logic [2:0] SizeByte = 3'd0;
    localparam logic [2:0] SizeHalf = 3'd1;
    localparam logic [2:0] SizeWord = 3'd2;

    localparam logic RespOkay  = 1'b0;
    localparam logic RespError = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane mask and natural-alignment flag for an AHB transfer size and low address bits.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] strb,
    output logic       aligned
);

    always_comb begin
        strb    = 4'b0000;
        aligned = 1'b0;
        case (size)
            SizeByte: begin
                strb    = 4'b0001 << addr;
                aligned = 1'b1;
            end
            SizeHalf: begin
                // addr[0] is ignored here, which is exactly the forced-alignment behaviour
                strb    = addr[1] ? 4'b1100 : 4'b0011;
                aligned = ~addr[0];
            end
            SizeWord: begin
                strb    = 4'b1111;
                aligned = (addr == 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_debug_mem_slave.sv
// AHB-Lite scratch-memory slave with programmable wait states and a two-cycle ERROR response.
// Define AHB_MISALIGN_ERR_EN to reject misaligned half/word transfers instead of aligning them.
module ahb_debug_mem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [2:0]  WaitCnt = 3'(WAIT_STATES);

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic            ready_q;
    logic            resp_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      strb_q;
    logic            write_q;
    logic [31:0]     mem [DEPTH];

    logic [3:0]      strb;
    logic            aligned;
    logic            accept;
    logic            illegal;
    logic [15:0]     hi_bits;
    logic            unused;

    ahb_byte_strobe u_strobe (
        .addr    (HADDR[1:0]),
        .size    (HSIZE),
        .strb    (strb),
        .aligned (aligned)
    );

    // New address phases are only sampled where this slave can be ready.
    assign accept = HSEL & HREADY & HTRANS[1] &
                    ((state_q == StIdle) | (state_q == StData) | (state_q == StErr2));

    assign hi_bits = HADDR[15:0] >> (AW + 2);

`ifdef AHB_MISALIGN_ERR_EN
    assign illegal = (HSIZE > SizeWord) | (|hi_bits) | ~aligned;
    assign unused  = ^{HBURST, HADDR[31:16], HTRANS[0]};
`else
    assign illegal = (HSIZE > SizeWord) | (|hi_bits);
    assign unused  = ^{HBURST, HADDR[31:16], HTRANS[0], aligned};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            ready_q <= 1'b1;
            resp_q  <= RespOkay;
            idx_q   <= '0;
            strb_q  <= 4'b0000;
            write_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q   <= HADDR[AW+1:2];
                strb_q  <= strb;
                write_q <= HWRITE;
                cnt_q   <= WaitCnt;
            end
            unique case (state_q)
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= StData;
                        ready_q <= 1'b1;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    ready_q <= 1'b1;
                    resp_q  <= RespError;
                end
                default: begin
                    if (accept && illegal) begin
                        state_q <= StErr1;
                        ready_q <= 1'b0;
                        resp_q  <= RespError;
                    end else if (accept && (WaitCnt != 3'd0)) begin
                        state_q <= StWait;
                        ready_q <= 1'b0;
                        resp_q  <= RespOkay;
                    end else if (accept) begin
                        state_q <= StData;
                        ready_q <= 1'b1;
                        resp_q  <= RespOkay;
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        resp_q  <= RespOkay;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if ((state_q == StData) && write_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;
    assign HRDATA    = (((state_q == StWait) || (state_q == StData)) && !write_q) ?
                       mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_debug_mem_slave.sv
// Directed bench: table of single transfers on a zero-wait and a three-wait instance,
// plus hand-written pipelined, error-pipelined and reset-abort sequences.
module tb_ahb_debug_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel3;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic        ro0, rsp0, ro3, rsp3;
    logic [31:0] rd0, rd3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_debug_mem_slave #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro0),
        .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0)
    );

    ahb_debug_mem_slave #(.DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .HSEL(sel3), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro3),
        .HREADYOUT(ro3), .HRESP(rsp3), .HRDATA(rd3)
    );

    typedef struct {
        string       name;
        bit          slow;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_low;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        sel0   = 1'b0;
        sel3   = 1'b0;
        htrans = 2'd0;
    endtask

    // One non-pipelined transfer starting from an idle bus.
    task automatic xfer(input bit slow, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output bit resp_first,
                        output bit resp_last, output int low);
        sel0 = !slow; sel3 = slow;
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'd2;
        @(posedge clk); #1;
        go_idle();
        hwdata = wd;
        low = 0;
        @(negedge clk);
        resp_first = slow ? rsp3 : rsp0;
        while (!(slow ? ro3 : ro0) && low < 20) begin
            low++;
            @(negedge clk);
        end
        rd        = slow ? rd3 : rd0;
        resp_last = slow ? rsp3 : rsp0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, rdv[2];
        bit          rf, rl;
        int          low, cyc, done, lows;
        bit          mis_err;
`ifdef AHB_MISALIGN_ERR_EN
        mis_err = 1'b1;
`else
        mis_err = 1'b0;
`endif
        tbl.push_back('{"rd_w5_reset",   0, 0, 32'h14, 3'd2, 32'h0,        32'h0,        0, 0});
        tbl.push_back('{"wr_w10",        0, 1, 32'h10, 3'd2, 32'h11223344, 32'h0,        0, 0});
        tbl.push_back('{"wr_byte13",     0, 1, 32'h13, 3'd0, 32'hAA000000, 32'h0,        0, 0});
        tbl.push_back('{"rd_after_byte", 0, 0, 32'h10, 3'd2, 32'h0,        32'hAA223344, 0, 0});
        tbl.push_back('{"wr_half10",     0, 1, 32'h10, 3'd1, 32'h00005566, 32'h0,        0, 0});
        tbl.push_back('{"rd_after_half", 0, 0, 32'h10, 3'd2, 32'h0,        32'hAA225566, 0, 0});
        tbl.push_back('{"wr_half16",     0, 1, 32'h16, 3'd1, 32'hBEEF0000, 32'h0,        0, 0});
        tbl.push_back('{"wr_byte15",     0, 1, 32'h15, 3'd0, 32'h00007700, 32'h0,        0, 0});
        tbl.push_back('{"rd_w14",        0, 0, 32'h14, 3'd2, 32'h0,        32'hBEEF7700, 0, 0});
        tbl.push_back('{"wr_last",       0, 1, 32'hFC, 3'd2, 32'h600DF00D, 32'h0,        0, 0});
        tbl.push_back('{"rd_last",       0, 0, 32'hFC, 3'd2, 32'h0,        32'h600DF00D, 0, 0});
        tbl.push_back('{"rd_hi_ignored", 0, 0, 32'h80000010, 3'd2, 32'h0,  32'hAA225566, 0, 0});
        tbl.push_back('{"wr_oor",        0, 1, 32'h100, 3'd2, 32'h12345678, 32'h0,       1, 1});
        tbl.push_back('{"wr_size3",      0, 1, 32'h10, 3'd3, 32'h12345678, 32'h0,        1, 1});
        tbl.push_back('{"rd_unchanged",  0, 0, 32'h10, 3'd2, 32'h0,        32'hAA225566, 0, 0});
        tbl.push_back('{"rd_oor",        0, 0, 32'h100, 3'd2, 32'h0,       32'h0,        1, 1});
        tbl.push_back('{"wr_misw02",     0, 1, 32'h02, 3'd2, 32'h01020304, 32'h0,
                        mis_err, mis_err ? 1 : 0});
        tbl.push_back('{"rd_w0",         0, 0, 32'h00, 3'd2, 32'h0,
                        mis_err ? 32'h0 : 32'h01020304, 0, 0});
        tbl.push_back('{"wr_mish31",     0, 1, 32'h31, 3'd1, 32'h0000ABCD, 32'h0,
                        mis_err, mis_err ? 1 : 0});
        tbl.push_back('{"rd_w30",        0, 0, 32'h30, 3'd2, 32'h0,
                        mis_err ? 32'h0 : 32'h0000ABCD, 0, 0});
        tbl.push_back('{"ws3_wr20",      1, 1, 32'h20, 3'd2, 32'hCAFEF00D, 32'h0,        0, 3});
        tbl.push_back('{"ws3_wr24",      1, 1, 32'h24, 3'd2, 32'h0BADC0DE, 32'h0,        0, 3});
        tbl.push_back('{"ws3_rd20",      1, 0, 32'h20, 3'd2, 32'h0,        32'hCAFEF00D, 0, 3});

        go_idle();
        haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hwdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, ro0}, 32'd1);
        check("reset_resp",  {31'b0, rsp0}, 32'd0);
        check("reset_rdata", rd0, 32'h0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            xfer(tbl[i].slow, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, rf, rl, low);
            check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
            check({tbl[i].name, "_resp"}, {30'b0, rf, rl}, {30'b0, tbl[i].exp_err, tbl[i].exp_err});
            check({tbl[i].name, "_wait"}, low, tbl[i].exp_low);
        end

        // Zero-wait write then pipelined read of the same word.
        sel0 = 1'b1; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge clk);
        check("pipe_wr_ready", {31'b0, ro0}, 32'd1);
        check("pipe_wr_rdata", rd0, 32'h0);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check("pipe_rd_ready", {31'b0, ro0}, 32'd1);
        check("pipe_rd_rdata", rd0, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Three-wait slave: two back-to-back reads.
        sel3 = 1'b1; haddr = 32'h20; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk); #1;
        haddr = 32'h24;
        cyc = 0; done = 0; lows = 0;
        while (done < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ro3) begin
                rdv[done] = rd3;
                done++;
            end else begin
                lows++;
            end
            @(posedge clk); #1;
            if (done >= 1) go_idle();
        end
        check("b2b_cycles", cyc, 8);
        check("b2b_low",    lows, 6);
        check("b2b_rd0",    rdv[0], 32'hCAFEF00D);
        check("b2b_rd1",    rdv[1], 32'h0BADC0DE);

        // Illegal transfer, next transfer accepted in the ERR2 cycle.
        sel0 = 1'b1; haddr = 32'h100; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk); #1;
        haddr = 32'h40;
        @(negedge clk);
        check("err1_flags", {30'b0, ro0, rsp0}, 32'b01);
        @(posedge clk); #1;
        @(negedge clk);
        check("err2_flags", {30'b0, ro0, rsp0}, 32'b11);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check("after_err_flags", {30'b0, ro0, rsp0}, 32'b10);
        check("after_err_rdata", rd0, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset during wait states abandons the write and clears memory.
        sel3 = 1'b1; haddr = 32'h28; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk); #1;
        go_idle();
        hwdata = 32'h55555555;
        @(negedge clk);
        check("abort_waiting", {31'b0, ro3}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_flags", {30'b0, ro3, rsp3}, 32'b10);
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 32'h28, 3'd2, 32'h0, rd, rf, rl, low);
        check("abort_no_write", rd, 32'h0);
        xfer(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rf, rl, low);
        check("reset_cleared", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
